// File: rtl/cpu_decode_queue.sv
// RV32I decode stage: DEPTH-entry instruction queue feeding one registered decoded-output slot.
// Latency 1 cycle through an empty queue; o_ready depends only on registered occupancy and i_flush, never on i_ready.
module cpu_decode_queue #(
    parameter int TAG_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic [31:0]          i_instruction,
    input  logic [31:0]          i_pc,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [31:0]          o_instruction,
    output logic [31:0]          o_pc,
    output logic [4:0]           o_inst_rs1,
    output logic [4:0]           o_inst_rs2,
    output logic [4:0]           o_inst_rd,
    output logic [31:0]          o_imm,
    output logic [2:0]           o_format,
    output logic                 o_illegal,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          instr;
        logic [31:0]          pc;
    } entry_t;

    typedef struct packed {
        entry_t      ent;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
    } dec_t;

    function automatic dec_t decode(input entry_t e);
        dec_t        d;
        logic [31:0] ins;
        fmt_e        f;
        d   = '0;
        ins = e.instr;
        case (ins[6:0])
            7'b0110011:                                     f = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: f = FMT_I;
            7'b0100011:                                     f = FMT_S;
            7'b1100011:                                     f = FMT_B;
            7'b0110111, 7'b0010111:                         f = FMT_U;
            7'b1101111:                                     f = FMT_J;
            default:                                        f = FMT_NONE;
        endcase
        if (ins[1:0] != 2'b11) begin
            f = FMT_NONE;
        end
        d.ent     = e;
        d.fmt     = f;
        d.illegal = (f == FMT_NONE);
        d.rs1     = (f == FMT_R || f == FMT_I || f == FMT_S || f == FMT_B) ? ins[19:15] : 5'd0;
        d.rs2     = (f == FMT_R || f == FMT_S || f == FMT_B) ? ins[24:20] : 5'd0;
        d.rd      = (f == FMT_R || f == FMT_I || f == FMT_U || f == FMT_J) ? ins[11:7] : 5'd0;
        case (f)
            FMT_R:   d.imm = {26'd0, ins[25:20]};
            FMT_I:   d.imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   d.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   d.imm = {ins[31:12], 12'd0};
            FMT_J:   d.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: d.imm = 32'd0;
        endcase
        return d;
    endfunction

    entry_t               mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 out_vld_q, out_vld_d;
    dec_t                 out_q, out_d;

    entry_t in_ent;
    logic   count_empty;
    logic   out_free;
    logic   enq;
    logic   pop;
    logic   bypass;
    logic   push;

    assign in_ent      = '{tag: i_tag, instr: i_instruction, pc: i_pc};
    assign count_empty = (count_q == '0);
    assign o_ready     = (count_q < CNT_WIDTH'(DEPTH)) && !i_flush;

    always_comb begin
        out_free  = !out_vld_q || i_ready;
        enq       = i_valid && o_ready;
        pop       = out_free && !count_empty;
        // An empty queue with a free output slot lets the new instruction skip storage.
        bypass    = out_free && count_empty && enq;
        push      = enq && !bypass;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;

        if (i_flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            out_vld_d = 1'b0;
        end else begin
            count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                out_d     = decode(mem_q[rd_ptr_q]);
                out_vld_d = 1'b1;
            end else if (bypass) begin
                out_d     = decode(in_ent);
                out_vld_d = 1'b1;
            end else if (out_free) begin
                out_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_ent;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    assign o_valid       = out_vld_q;
    assign o_tag         = out_q.ent.tag;
    assign o_instruction = out_q.ent.instr;
    assign o_pc          = out_q.ent.pc;
    assign o_inst_rs1    = out_q.rs1;
    assign o_inst_rs2    = out_q.rs2;
    assign o_inst_rd     = out_q.rd;
    assign o_imm         = out_q.imm;
    assign o_format      = out_q.fmt;
    assign o_illegal     = out_q.illegal;
    assign o_count       = count_q;

endmodule
